ds_feeder: RTL and testbench
============================

// Module: ds_feeder
// PURPOSE
//  Upstream feeder for the first-order delta-sigma DAC. Buffers 16-bit audio words from the
//  host in a small FIFO and hands one word to the modulator's holding register (d/wd) whenever
//  the modulator reports ready. Also generates the modulator's bit-stream sample strobe from
//  clk through a programmable divider.
// PARAMETERS
//  AW     3   FIFO address width; depth = 2**AW words
//  DIV_W  16  width of the sample-rate divider
// PORTS
//  clk        in   1      system clock; all logic on posedge
//  reset      in   1      asynchronous, active-high reset
//  wr         in   1      host write strobe; din is pushed when wr=1 and full=0
//  din        in   16     host audio word, two's complement
//  div        in   DIV_W  sample-strobe divider; strobe period = div+1 clocks
//  clr        in   1      synchronous clear of the sticky flags
//  ds_ready   in   1      modulator holding register is empty
//  d          out  16     word presented to the modulator
//  wd         out  1      one-cycle write strobe to the modulator
//  sample     out  1      one-cycle bit-stream sample strobe
//  full       out  1      FIFO holds 2**AW words
//  empty      out  1      FIFO holds 0 words
//  level      out  AW+1   FIFO occupancy, 0..2**AW
//  overflow   out  1      sticky: a write was dropped because the FIFO was full
// BEHAVIOUR
//  Reset: d=0, wd=0, sample=0, empty=1, full=0, level=0, overflow=0, FSM=IDLE, div counter=0.
//  Sample divider (registered):
//   - cnt==0: sample<=1, cnt<=div. Otherwise sample<=0, cnt<=cnt-1.
//   - First strobe comes on the first edge after reset release. div=0 gives sample every clock.
//   - A change to div takes effect at the next reload only.
//  FIFO: first-word-fall-through head; a push and a pop in the same cycle are both legal.
//   - The push is evaluated against full before the pop. A write while full is dropped
//     (overflow<=1) even if a pop happens in the same cycle.
//   - A write while empty stores the word. No pop is possible in that cycle.
//   - Pointers wrap modulo 2**AW; level is updated by +1, -1, or unchanged.
//  Hand-off FSM (all outputs registered):
//   - IDLE: if ds_ready && !empty, then d<=head, wd<=1, pop, go to WAIT.
//   - WAIT: wd<=0, go to IDLE. This one cycle is mandatory because the modulator clears ready
//     only on the edge that samples wd. Without it a second word would overwrite the first.
//   - Result: at most one wd every 2 clocks. Latency from push into an empty FIFO with
//     ds_ready=1 to wd high is 2 clocks.
//   - d holds its last value between strobes.
//  clr clears overflow. If clr and a new overflow event occur in the same cycle, the set wins.
//  Reset mid-transfer aborts the transfer, and FIFO contents are discarded.
// CONFIGURATION
//  `define DS_FEEDER_MUTE_EN
//   - Defined: in IDLE with ds_ready=1 and empty=1, the FSM writes d<=16'h0000 (wd pulse,
//     then WAIT). The modulator outputs silence instead of holding the last word as DC.
//     A sticky output underrun (1 bit, cleared by clr) is added and set on each mute write.
//   - Undefined: no write occurs while empty, the modulator repeats its last word, and the
//     underrun port does not exist.
// STRUCTURE
//  Package ds_pkg: localparam SAMPLE_W=16; enum {FEED_IDLE, FEED_WAIT} feed_state_t; MUTE_WORD=16'h0000.
//  Sub-module ds_fifo (push/pop, full/empty/level, FWFT head) instanced once.
//  Divider and FSM live in ds_feeder.
// TESTING
//  1 div=3, no writes -> sample pulses at cycles 1,5,9,... after reset release (period 4).
//  2 ds_ready=1, push 16'h1234 into empty FIFO -> wd=1 with d=16'h1234 two clocks later;
//    empty=1 afterwards.
//  3 Push 3 words, ds_ready held 1 (model ignoring wd) -> wd pulses exactly every 2 clocks,
//    data in order, never back-to-back.
//  4 AW=3: push 9 words with ds_ready=0 -> full=1, level=8, overflow=1, 9th word lost;
//    clr -> overflow=0.
//  5 Full FIFO, wr and pop same cycle -> write dropped, level=7, overflow=1.
//  6 Reset asserted during WAIT with level=4 -> all outputs at reset values immediately;
//    after release empty=1 and no wd. With DS_FEEDER_MUTE_EN: empty FIFO and ds_ready=1
//    -> wd with d=0 and underrun=1.

Source files
------------

// File: rtl/ds_pkg.sv
// Shared types and constants for the delta-sigma DAC feeder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ds_pkg;

    localparam int SAMPLE_W = 16;

    // Word written to the modulator when it starves and muting is built in.
    localparam logic [SAMPLE_W-1:0] MUTE_WORD = 16'h0000;

    typedef enum logic {
        FEED_IDLE = 1'b0,
        FEED_WAIT = 1'b1
    } feed_state_t;

endpackage

// File: rtl/ds_fifo.sv
// Small first-word-fall-through FIFO holding audio words for the modulator feeder.
// Latency: a pushed word is visible on o_head one clock after the push edge.
// Backpressure: pushes while full are dropped and flagged on o_drop; pops while empty are ignored.
module ds_fifo
    import ds_pkg::*;
#(
    parameter int AW = 3,
    parameter int W  = SAMPLE_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  logic [W-1:0]  i_din,
    input  logic          i_pop,
    output logic [W-1:0]  o_head,
    output logic          o_full,
    output logic          o_empty,
    output logic          o_drop,
    output logic [AW:0]   o_level
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [W-1:0]  r_mem [2**AW];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;

    logic          w_full;
    logic          w_empty;
    logic          w_push_ok;
    logic          w_pop_ok;

    // Full is judged before any same-cycle pop, so a write into a full FIFO is always lost.
    assign w_full    = (r_level == DEPTH);
    assign w_empty   = (r_level == '0);
    assign w_push_ok = i_push && !w_full;
    assign w_pop_ok  = i_pop && !w_empty;

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_drop  = i_push && w_full;
    assign o_level = r_level;

    // Storage array carries no reset; contents are qualified by the level count.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers wrap naturally at 2**AW; level moves by at most one per clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/ds_feeder.sv
// Feeds buffered host audio words to the delta-sigma modulator and generates its sample strobe.
// Latency: push into empty FIFO with ds_ready high gives wd two clocks later; at most one wd per 2 clocks.
// Backpressure: holds words while ds_ready is low; host writes while full are dropped (sticky overflow).
// Build option DS_FEEDER_MUTE_EN: write silence (and set sticky underrun) when the modulator starves.
module ds_feeder
    import ds_pkg::*;
#(
    parameter int AW    = 3,
    parameter int DIV_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr,
    input  logic [SAMPLE_W-1:0] din,
    input  logic [DIV_W-1:0]    div,
    input  logic                clr,
    input  logic                ds_ready,
    output logic [SAMPLE_W-1:0] d,
    output logic                wd,
    output logic                sample,
    output logic                full,
    output logic                empty,
    output logic [AW:0]         level,
    output logic                overflow
`ifdef DS_FEEDER_MUTE_EN
    ,
    output logic                underrun
`endif
);

    logic [DIV_W-1:0]    r_cnt;
    logic                r_sample;

    feed_state_t         r_state;
    feed_state_t         w_state_nxt;
    logic [SAMPLE_W-1:0] r_d;
    logic [SAMPLE_W-1:0] w_d_nxt;
    logic                r_wd;
    logic                w_wd_nxt;
    logic                w_pop;
    logic                r_overflow;

    logic [SAMPLE_W-1:0] w_head;
    logic                w_full;
    logic                w_empty;
    logic                w_drop;
    logic [AW:0]         w_level;

`ifdef DS_FEEDER_MUTE_EN
    logic                r_underrun;
    logic                w_under_set;
`endif

    ds_fifo #(
        .AW (AW),
        .W  (SAMPLE_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (wr),
        .i_din   (din),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_drop  (w_drop),
        .o_level (w_level)
    );

    // Sample-rate divider: strobe on reload; a new div value is only picked up at reload.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_sample <= 1'b0;
        end else if (r_cnt == '0) begin
            r_cnt    <= div;
            r_sample <= 1'b1;
        end else begin
            r_cnt    <= r_cnt - 1'b1;
            r_sample <= 1'b0;
        end
    end

    // Hand-off next-state logic; WAIT gives the modulator one edge to drop ready after wd.
    always_comb begin
        w_state_nxt = r_state;
        w_d_nxt     = r_d;
        w_wd_nxt    = 1'b0;
        w_pop       = 1'b0;
`ifdef DS_FEEDER_MUTE_EN
        w_under_set = 1'b0;
`endif
        case (r_state)
            FEED_IDLE: begin
                if (ds_ready && !w_empty) begin
                    w_d_nxt     = w_head;
                    w_wd_nxt    = 1'b1;
                    w_pop       = 1'b1;
                    w_state_nxt = FEED_WAIT;
                end
`ifdef DS_FEEDER_MUTE_EN
                else if (ds_ready) begin
                    w_d_nxt     = MUTE_WORD;
                    w_wd_nxt    = 1'b1;
                    w_under_set = 1'b1;
                    w_state_nxt = FEED_WAIT;
                end
`endif
            end
            FEED_WAIT: begin
                w_state_nxt = FEED_IDLE;
            end
            default: begin
                w_state_nxt = FEED_IDLE;
            end
        endcase
    end

    // Hand-off state and registered modulator interface; d holds between strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= FEED_IDLE;
            r_d     <= '0;
            r_wd    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_d     <= w_d_nxt;
            r_wd    <= w_wd_nxt;
        end
    end

    // Sticky overflow; a new drop in the same cycle as clr keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr) begin
            r_overflow <= 1'b0;
        end
    end

`ifdef DS_FEEDER_MUTE_EN
    // Sticky underrun, set on every mute write; set wins over clr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_underrun <= 1'b0;
        end else if (w_under_set) begin
            r_underrun <= 1'b1;
        end else if (clr) begin
            r_underrun <= 1'b0;
        end
    end

    assign underrun = r_underrun;
`endif

    assign d        = r_d;
    assign wd       = r_wd;
    assign sample   = r_sample;
    assign full     = w_full;
    assign empty    = w_empty;
    assign level    = w_level;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_ds_feeder.sv
// Directed bench for ds_feeder: divider, hand-off timing, FIFO limits, overflow and reset abort.
// Latency: n/a.
// Backpressure: n/a.
module tb_ds_feeder;

    logic        clk;
    logic        reset;
    logic        wr;
    logic [15:0] din;
    logic [15:0] div;
    logic        clr;
    logic        ds_ready;
    logic [15:0] d;
    logic        wd;
    logic        sample;
    logic        full;
    logic        empty;
    logic [3:0]  level;
    logic        overflow;
`ifdef DS_FEEDER_MUTE_EN
    logic        underrun;
`endif

    int n_checks;
    int n_errors;

    ds_feeder #(
        .AW    (3),
        .DIV_W (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr       (wr),
        .din      (din),
        .div      (div),
        .clr      (clr),
        .ds_ready (ds_ready),
        .d        (d),
        .wd       (wd),
        .sample   (sample),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow)
`ifdef DS_FEEDER_MUTE_EN
        ,
        .underrun (underrun)
`endif
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (d !== 16'h0000)  begin $display("FAIL reset_d got %h exp 0000", d); n_errors++; end
        n_checks++; if (wd !== 1'b0)     begin $display("FAIL reset_wd got %b exp 0", wd); n_errors++; end
        n_checks++; if (sample !== 1'b0) begin $display("FAIL reset_sample got %b exp 0", sample); n_errors++; end
        n_checks++; if (empty !== 1'b1)  begin $display("FAIL reset_empty got %b exp 1", empty); n_errors++; end
        n_checks++; if (full !== 1'b0)   begin $display("FAIL reset_full got %b exp 0", full); n_errors++; end
        n_checks++; if (level !== 4'd0)  begin $display("FAIL reset_level got %0d exp 0", level); n_errors++; end
        n_checks++; if (overflow !== 1'b0) begin $display("FAIL reset_overflow got %b exp 0", overflow); n_errors++; end
        reset = 1'b0;
    endtask

    // div=3 from reset: strobes on edges 1,5,9; then div=0 strobes every edge.
    task automatic test_divider();
        logic exp_s;
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp_s = ((k - 1) % 4 == 0);
            n_checks++;
            if (sample !== exp_s) begin
                $display("FAIL div3_sample edge %0d got %b exp %b", k, sample, exp_s); n_errors++;
            end
        end
        div = 16'd0;
        for (int k = 13; k <= 15; k++) begin
            tick();
            n_checks++;
            if (sample !== 1'b1) begin
                $display("FAIL div0_sample edge %0d got %b exp 1", k, sample); n_errors++;
            end
        end
    endtask

    task automatic test_single();
        ds_ready = 1'b1;
        wr = 1'b1;
        din = 16'h1234;
        tick();
        wr = 1'b0;
        n_checks++; if (wd !== 1'b0)    begin $display("FAIL single_wd_early got %b exp 0", wd); n_errors++; end
        n_checks++; if (level !== 4'd1) begin $display("FAIL single_level got %0d exp 1", level); n_errors++; end
        tick();
        n_checks++; if (wd !== 1'b1)     begin $display("FAIL single_wd got %b exp 1", wd); n_errors++; end
        n_checks++; if (d !== 16'h1234)  begin $display("FAIL single_d got %h exp 1234", d); n_errors++; end
        n_checks++; if (empty !== 1'b1)  begin $display("FAIL single_empty got %b exp 1", empty); n_errors++; end
        tick();
        n_checks++; if (wd !== 1'b0)     begin $display("FAIL single_wd_drop got %b exp 0", wd); n_errors++; end
        n_checks++; if (d !== 16'h1234)  begin $display("FAIL single_d_hold got %h exp 1234", d); n_errors++; end
    endtask

    // Three pushes on consecutive edges with ds_ready stuck high: wd on edges 2,4,6 only.
    task automatic test_back_to_back();
        logic [15:0] w [3];
        logic        exp_wd;
        w[0] = 16'hA001;
        w[1] = 16'hA002;
        w[2] = 16'hA003;
        ds_ready = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            if (k <= 3) begin
                wr = 1'b1;
                din = w[k-1];
            end else begin
                wr = 1'b0;
            end
            tick();
            exp_wd = (k == 2) || (k == 4) || (k == 6);
            n_checks++;
            if (wd !== exp_wd) begin
                $display("FAIL b2b_wd edge %0d got %b exp %b", k, wd, exp_wd); n_errors++;
            end
            if (exp_wd) begin
                n_checks++;
                if (d !== w[k/2-1]) begin
                    $display("FAIL b2b_d edge %0d got %h exp %h", k, d, w[k/2-1]); n_errors++;
                end
            end
        end
        wr = 1'b0;
    endtask

    task automatic test_overflow();
        ds_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            wr = 1'b1;
            din = 16'h0100 + 16'(i);
            tick();
        end
        wr = 1'b0;
        n_checks++; if (full !== 1'b1)     begin $display("FAIL ovf_full got %b exp 1", full); n_errors++; end
        n_checks++; if (level !== 4'd8)    begin $display("FAIL ovf_level got %0d exp 8", level); n_errors++; end
        n_checks++; if (overflow !== 1'b1) begin $display("FAIL ovf_flag got %b exp 1", overflow); n_errors++; end
        n_checks++; if (empty !== 1'b0)    begin $display("FAIL ovf_empty got %b exp 0", empty); n_errors++; end
        // clr together with a fresh drop: the set must win
        clr = 1'b1;
        wr = 1'b1;
        din = 16'hBEEF;
        tick();
        wr = 1'b0;
        n_checks++; if (overflow !== 1'b1) begin $display("FAIL ovf_set_wins got %b exp 1", overflow); n_errors++; end
        n_checks++; if (level !== 4'd8)    begin $display("FAIL ovf_level_hold got %0d exp 8", level); n_errors++; end
        tick();
        clr = 1'b0;
        n_checks++; if (overflow !== 1'b0) begin $display("FAIL ovf_clr got %b exp 0", overflow); n_errors++; end
    endtask

    // Write and pop in the same cycle on a full FIFO: write lost, then drain in order.
    task automatic test_full_pop();
        int idx;
        ds_ready = 1'b1;
        wr = 1'b1;
        din = 16'hDEAD;
        tick();
        wr = 1'b0;
        n_checks++; if (wd !== 1'b1)       begin $display("FAIL fpop_wd got %b exp 1", wd); n_errors++; end
        n_checks++; if (d !== 16'h0100)    begin $display("FAIL fpop_d got %h exp 0100", d); n_errors++; end
        n_checks++; if (level !== 4'd7)    begin $display("FAIL fpop_level got %0d exp 7", level); n_errors++; end
        n_checks++; if (overflow !== 1'b1) begin $display("FAIL fpop_overflow got %b exp 1", overflow); n_errors++; end
        n_checks++; if (full !== 1'b0)     begin $display("FAIL fpop_full got %b exp 0", full); n_errors++; end
        idx = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (wd === 1'b1) begin
                n_checks++;
                if (d !== 16'h0101 + 16'(idx)) begin
                    $display("FAIL drain_d word %0d got %h exp %h", idx, d, 16'h0101 + 16'(idx)); n_errors++;
                end
                idx++;
            end
        end
        n_checks++; if (idx != 7)        begin $display("FAIL drain_count got %0d exp 7", idx); n_errors++; end
        n_checks++; if (empty !== 1'b1)  begin $display("FAIL drain_empty got %b exp 1", empty); n_errors++; end
    endtask

    // Reset while in WAIT with four words queued; overflow is still set from before.
    task automatic test_reset_mid();
        ds_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr = 1'b1;
            din = 16'h0200 + 16'(i);
            tick();
        end
        wr = 1'b0;
        ds_ready = 1'b1;
        tick();
        n_checks++; if (wd !== 1'b1)    begin $display("FAIL rmid_wd got %b exp 1", wd); n_errors++; end
        n_checks++; if (level !== 4'd4) begin $display("FAIL rmid_level got %0d exp 4", level); n_errors++; end
        #1;
        reset = 1'b1;
        #1;
        n_checks++; if (wd !== 1'b0)       begin $display("FAIL rmid_rst_wd got %b exp 0", wd); n_errors++; end
        n_checks++; if (d !== 16'h0000)    begin $display("FAIL rmid_rst_d got %h exp 0000", d); n_errors++; end
        n_checks++; if (level !== 4'd0)    begin $display("FAIL rmid_rst_level got %0d exp 0", level); n_errors++; end
        n_checks++; if (empty !== 1'b1)    begin $display("FAIL rmid_rst_empty got %b exp 1", empty); n_errors++; end
        n_checks++; if (overflow !== 1'b0) begin $display("FAIL rmid_rst_overflow got %b exp 0", overflow); n_errors++; end
        n_checks++; if (sample !== 1'b0)   begin $display("FAIL rmid_rst_sample got %b exp 0", sample); n_errors++; end
        tick();
        reset = 1'b0;
`ifdef DS_FEEDER_MUTE_EN
        tick();
        n_checks++; if (wd !== 1'b1)       begin $display("FAIL mute_wd got %b exp 1", wd); n_errors++; end
        n_checks++; if (d !== 16'h0000)    begin $display("FAIL mute_d got %h exp 0000", d); n_errors++; end
        n_checks++; if (underrun !== 1'b1) begin $display("FAIL mute_underrun got %b exp 1", underrun); n_errors++; end
`else
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if (wd !== 1'b0) begin $display("FAIL rmid_post_wd edge %0d got %b exp 0", k, wd); n_errors++; end
            n_checks++;
            if (empty !== 1'b1) begin $display("FAIL rmid_post_empty edge %0d got %b exp 1", k, empty); n_errors++; end
        end
`endif
    endtask

    initial begin
        clk      = 1'b0;
        reset    = 1'b1;
        wr       = 1'b0;
        din      = 16'h0000;
        div      = 16'd3;
        clr      = 1'b0;
        ds_ready = 1'b0;
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_divider();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got running exp finished");
        $fatal(1, "watchdog");
    end

endmodule
